// File: rtl/serial_parity_pkg.sv
// rtl/serial_parity_pkg.sv - shared types and line constants for the serial parity link
package serial_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - 1-bit XOR parity accumulator with synchronous clear
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    // clear wins over enable; enable folds the next bit into the running XOR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - serial frame receiver with XOR parity and stop-bit check
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    rx_state_t         state;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] sreg;
    logic              perr;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;

    // accumulator restarts on the start bit and absorbs only data bits
    assign acc_clr = bit_en && (state == IDLE) && (rx_in == START_BIT);
    assign acc_en  = bit_en && (state == DATA);

    parity_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (rx_in),
        .acc   (acc)
    );

    assign busy = (state != IDLE);

    // frame FSM: advances only on bit strobes; results are published the cycle after the stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            sreg       <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (rx_in == START_BIT) begin
                            state <= DATA;
                            count <= '0;
                            sreg  <= '0;
                        end
                    end
                    DATA: begin
                        sreg  <= sreg | (DATA_W'(rx_in) << count);
                        count <= count + 1'b1;
                        if (count == CW'(DATA_W - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        perr  <= acc ^ rx_in ^ PARITY_ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        data_out   <= sreg;
                        parity_err <= perr;
                        frame_err  <= ~rx_in;
                        data_valid <= 1'b1;
                        state      <= (rx_in == STOP_BIT) ? IDLE : BREAK;
                    end
                    BREAK: begin
                        if (rx_in == STOP_BIT) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - directed self-checking bench for serial_parity_rx
module tb_serial_parity_rx;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       rx0;
    logic       rx1;
    logic [7:0] data0, data1;
    logic       dv0, dv1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    int vectors;
    int miscompares;
    int dv_cnt0;
    int dv_cnt1;

    logic       got_dv, got_dv_next, got_perr, got_ferr;
    logic [7:0] got_data;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx0),
        .bit_en     (bit_en),
        .data_out   (data0),
        .data_valid (dv0),
        .parity_err (perr0),
        .frame_err  (ferr0),
        .busy       (busy0)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx1),
        .bit_en     (bit_en),
        .data_out   (data1),
        .data_valid (dv1),
        .parity_err (perr1),
        .frame_err  (ferr1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dv0) dv_cnt0 = dv_cnt0 + 1;
        if (dv1) dv_cnt1 = dv_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one bit period of 4 clocks, strobe in the first cycle
    task automatic send_bit(input int which, input logic b);
        @(negedge clk);
        if (which == 0) rx0 = b; else rx1 = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // full frame; captures outputs in the cycle after the stop sample and the one after that
    task automatic send_frame(input int which, input logic [7:0] d, input logic p, input logic s);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        send_bit(which, p);
        @(negedge clk);
        if (which == 0) rx0 = s; else rx1 = s;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en   = 1'b0;
        got_dv   = (which == 0) ? dv0 : dv1;
        got_data = (which == 0) ? data0 : data1;
        got_perr = (which == 0) ? perr0 : perr1;
        got_ferr = (which == 0) ? ferr0 : ferr1;
        @(negedge clk);
        got_dv_next = (which == 0) ? dv0 : dv1;
        @(negedge clk);
    endtask

    initial begin
        int snap;
        vectors     = 0;
        miscompares = 0;
        dv_cnt0     = 0;
        dv_cnt1     = 0;
        rst_n       = 1'b0;
        bit_en      = 1'b0;
        rx0         = 1'b1;
        rx1         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data0}, 32'h0);
        check("rst_flags", {28'd0, dv0, perr0, ferr0, busy0}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good frame
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        check("t1_dv", {31'd0, got_dv}, 32'd1);
        check("t1_dv_pulse", {31'd0, got_dv_next}, 32'd0);
        check("t1_data", {24'd0, got_data}, 32'hA5);
        check("t1_perr", {31'd0, got_perr}, 32'd0);
        check("t1_ferr", {31'd0, got_ferr}, 32'd0);
        check("t1_busy", {31'd0, busy0}, 32'd0);

        // 2: parity error, then recovery
        send_frame(0, 8'h01, 1'b0, 1'b1);
        check("t2_data", {24'd0, got_data}, 32'h01);
        check("t2_perr", {31'd0, got_perr}, 32'd1);
        check("t2_ferr", {31'd0, got_ferr}, 32'd0);
        send_frame(0, 8'h03, 1'b0, 1'b1);
        check("t2_data2", {24'd0, got_data}, 32'h03);
        check("t2_perr2", {31'd0, got_perr}, 32'd0);

        // 3: framing error into break
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check("t3_dv", {31'd0, got_dv}, 32'd1);
        check("t3_data", {24'd0, got_data}, 32'h3C);
        check("t3_ferr", {31'd0, got_ferr}, 32'd1);
        check("t3_perr", {31'd0, got_perr}, 32'd0);
        snap = dv_cnt0;
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
        check("t3_break_busy", {31'd0, busy0}, 32'd1);
        check("t3_break_nodv", snap, dv_cnt0);
        send_bit(0, 1'b1);
        check("t3_idle_busy", {31'd0, busy0}, 32'd0);
        check("t3_ferr_held", {31'd0, ferr0}, 32'd1);

        // 4: reset mid-frame
        snap = dv_cnt0;
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        check("t4_busy_pre", {31'd0, busy0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_data", {24'd0, data0}, 32'h0);
        check("t4_rst_flags", {28'd0, dv0, perr0, ferr0, busy0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rx0   = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_nodv", dv_cnt0, snap);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        check("t4_dv", {31'd0, got_dv}, 32'd1);
        check("t4_data", {24'd0, got_data}, 32'h5A);
        check("t4_perr", {31'd0, got_perr}, 32'd0);

        // 5: back-to-back frames
        snap = dv_cnt0;
        send_frame(0, 8'h12, 1'b0, 1'b1);
        check("t5_data_a", {24'd0, got_data}, 32'h12);
        check("t5_perr_a", {31'd0, got_perr}, 32'd0);
        send_frame(0, 8'h34, 1'b1, 1'b1);
        check("t5_data_b", {24'd0, got_data}, 32'h34);
        check("t5_perr_b", {31'd0, got_perr}, 32'd0);
        check("t5_dv_count", dv_cnt0 - snap, 32'd2);

        // 6: odd parity instance
        send_frame(1, 8'h00, 1'b1, 1'b1);
        check("t6_dv", {31'd0, got_dv}, 32'd1);
        check("t6_perr_ok", {31'd0, got_perr}, 32'd0);
        send_frame(1, 8'h00, 1'b0, 1'b1);
        check("t6_perr_bad", {31'd0, got_perr}, 32'd1);
        check("t6_dv_count", dv_cnt1, 32'd2);
        @(negedge clk);
        rx1 = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_no_strobe_busy", {31'd0, busy1}, 32'd0);
        rx1 = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
